evt_crc_buffer: RTL and testbench



---
 rtl/evt_crc_buffer_pkg.sv | 24 ++
 rtl/evt_dpram.sv | 44 ++++
 rtl/evt_crc_buffer.sv | 95 +++++++++
 tb/tb_evt_crc_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_crc_buffer_pkg.sv
// Shared constants, CRC state type and the serial CRC-6 step for the event CRC buffer.
package evt_crc_buffer_pkg;

    localparam int unsigned CRC_W      = 6;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 12;

    // Low terms of x^6 + x + 1
    localparam logic [CRC_W-1:0] CRC_POLY = 6'b000011;

    typedef enum logic {
        CRC_IDLE   = 1'b0,
        CRC_ACTIVE = 1'b1
    } crc_state_e;

    // Shift one serial bit into the CRC register
    function automatic logic [CRC_W-1:0] crc6_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
    endfunction

endpackage

// File: rtl/evt_dpram.sv
// Event memory: port A write-first write/read-back, port B registered read (read-first on collision).
module evt_dpram
    import evt_crc_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] WrDataOut,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents carry no reset so they survive a reset pulse and map to block RAM
    always_ff @(posedge Clock) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            WrDataOut <= '0;
            RdData    <= '0;
        end else begin
            if (WrEn) begin
                WrDataOut <= WrData;
            end
            if (RdEn) begin
                RdData <= mem[RdAddr];
            end
        end
    end

endmodule

// File: rtl/evt_crc_buffer.sv
// Serial CRC-6 accumulator (Start..Stop) plus 2**ADDR_W x DATA_W dual-port event memory.
// Define EVT_CRC_DEBUG_EN to print Address and CRCnew in simulation on the cycle after Stop.
module evt_crc_buffer
    import evt_crc_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              DataDly,
    input  logic              Start,
    input  logic              Stop,
    input  logic [3:0]        Address,
    output logic [CRC_W-1:0]  CRCnew,
    input  logic              WrEn,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] WrDataOut,
    output logic [DATA_W-1:0] RdData
);

    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             stop_hit;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= CRC_IDLE;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
        end
    end

    // Start reinitialises and wins over Stop; Stop outside an event is ignored
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        stop_hit = 1'b0;
        if (Start) begin
            crc_d    = crc6_step(CRC_W'(0), DataDly);
            state_d  = Stop ? CRC_IDLE : CRC_ACTIVE;
            stop_hit = Stop;
        end else if (state_q == CRC_ACTIVE) begin
            crc_d = crc6_step(crc_q, DataDly);
            if (Stop) begin
                state_d  = CRC_IDLE;
                stop_hit = 1'b1;
            end
        end
    end

    assign CRCnew = crc_q;

`ifdef EVT_CRC_DEBUG_EN
    logic dbg_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            dbg_q <= 1'b0;
        end else begin
            dbg_q <= stop_hit;
        end
    end

    always @(negedge Clock) begin
        if (dbg_q) begin
            $display("%0t evt_crc_buffer addr=%0h crc=%b", $time, Address, CRCnew);
        end
    end
`else
    logic unused_dbg;
    assign unused_dbg = ^{Address, stop_hit};
`endif

    evt_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dpram (
        .Clock     (Clock),
        .Reset     (Reset),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .WrDataOut (WrDataOut),
        .RdEn      (RdEn),
        .RdAddr    (RdAddr),
        .RdData    (RdData)
    );

endmodule

// File: tb/tb_evt_crc_buffer.sv
// Self-checking bench for evt_crc_buffer: directed plus randomized CRC events and memory traffic.
module tb_evt_crc_buffer;

    logic        Clock;
    logic        Reset;
    logic        DataDly;
    logic        Start;
    logic        Stop;
    logic [3:0]  Address;
    logic [5:0]  CRCnew;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  WrAddr;
    logic [7:0]  RdAddr;
    logic [11:0] WrData;
    logic [11:0] WrDataOut;
    logic [11:0] RdData;

    int checks = 0;
    int errors = 0;

    logic [11:0] mdl [256];
    logic [11:0] exp_rd;
    logic [11:0] exp_wr;

    evt_crc_buffer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .DataDly   (DataDly),
        .Start     (Start),
        .Stop      (Stop),
        .Address   (Address),
        .CRCnew    (CRCnew),
        .WrEn      (WrEn),
        .RdEn      (RdEn),
        .WrAddr    (WrAddr),
        .RdAddr    (RdAddr),
        .WrData    (WrData),
        .WrDataOut (WrDataOut),
        .RdData    (RdData)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^6 divided by x^6+x+1; bits[n-1] is sent first
    function automatic logic [5:0] ref_crc(input logic [63:0] bits, input int n);
        logic [69:0] v;
        v = {bits, 6'b0};
        for (int i = n + 5; i >= 6; i--) begin
            if (v[i]) v[i -: 7] = v[i -: 7] ^ 7'b1000011;
        end
        return v[5:0];
    endfunction

    function automatic logic [63:0] rand_bits(input int n);
        logic [63:0] b;
        b = {$urandom, $urandom};
        if (n < 64) b = b & ((64'd1 << n) - 64'd1);
        return b;
    endfunction

    // One event of n bits: Start on the first bit, Stop on the last
    task automatic run_event(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            DataDly = bits[n-1-i];
            Start   = (i == 0);
            Stop    = (i == n - 1);
            tick();
        end
        Start = 1'b0;
        Stop  = 1'b0;
    endtask

    // Idle cycles with noise on DataDly and stray Stop strobes; CRC must hold
    task automatic idle_hold(input logic [5:0] expv, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            DataDly = 1'($urandom);
            Stop    = 1'($urandom);
            tick();
            check("crc_hold", 32'(CRCnew), 32'(expv));
        end
        Stop = 1'b0;
    endtask

    task automatic mem_cycle(input logic we, input logic [7:0] wa, input logic [11:0] wd,
                             input logic re, input logic [7:0] ra);
        WrEn   = we;
        WrAddr = wa;
        WrData = wd;
        RdEn   = re;
        RdAddr = ra;
        if (re) exp_rd = mdl[ra];
        if (we) begin
            mdl[wa] = wd;
            exp_wr  = wd;
        end
        tick();
        check("wr_dataout", 32'(WrDataOut), 32'(exp_wr));
        check("rd_data", 32'(RdData), 32'(exp_rd));
    endtask

    initial begin
        logic [63:0] bits;
        logic [5:0]  expc;
        int          n;

        Reset   = 1'b0;
        DataDly = 1'b0;
        Start   = 1'b0;
        Stop    = 1'b0;
        Address = 4'h9;
        WrEn    = 1'b0;
        RdEn    = 1'b0;
        WrAddr  = '0;
        RdAddr  = '0;
        WrData  = '0;
        #13;
        check("rst_crc", 32'(CRCnew), 32'd0);
        check("rst_rd", 32'(RdData), 32'd0);
        check("rst_wr", 32'(WrDataOut), 32'd0);
        tick();
        Reset = 1'b1;
        tick();
        check("crc_idle_after_rst", 32'(CRCnew), 32'd0);

        // Start and Stop together with a 1 bit
        DataDly = 1'b1; Start = 1'b1; Stop = 1'b1;
        tick();
        Start = 1'b0; Stop = 1'b0;
        check("crc_startstop", 32'(CRCnew), 32'h03);
        idle_hold(6'b000011, 3);

        // Two-bit event 1,0
        DataDly = 1'b1; Start = 1'b1;
        tick();
        DataDly = 1'b0; Start = 1'b0; Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check("crc_two_bit", 32'(CRCnew), 32'h06);
        idle_hold(6'b000110, 2);

        // Randomized events, some restarted part-way through
        for (int e = 0; e < 24; e++) begin
            if (e % 4 == 3) begin
                n = 1 + int'($urandom_range(0, 9));
                bits = rand_bits(n);
                for (int i = 0; i < n; i++) begin
                    DataDly = bits[i];
                    Start   = (i == 0);
                    tick();
                end
            end
            n = 1 + int'($urandom_range(0, 47));
            bits = rand_bits(n);
            run_event(bits, n);
            expc = ref_crc(bits, n);
            check("crc_rand", 32'(CRCnew), 32'(expc));
            idle_hold(expc, 1 + int'($urandom_range(0, 2)));
        end

        // Reset mid-stream, then a fresh event
        bits = rand_bits(20);
        for (int i = 0; i < 10; i++) begin
            DataDly = bits[19-i];
            Start   = (i == 0);
            tick();
        end
        Start = 1'b0;
        Reset = 1'b0;
        #1;
        check("crc_midreset", 32'(CRCnew), 32'd0);
        #1;
        Reset = 1'b1;
        idle_hold(6'd0, 2);
        bits = rand_bits(20);
        run_event(bits, 20);
        check("crc_after_reset", 32'(CRCnew), 32'(ref_crc(bits, 20)));

        // Memory: write then read back
        exp_rd = '0;
        exp_wr = '0;
        mem_cycle(1'b1, 8'h05, 12'hABC, 1'b0, 8'h00);
        mem_cycle(1'b0, 8'h00, 12'h000, 1'b1, 8'h05);
        check("rd_abc", 32'(RdData), 32'hABC);

        // Same-address collision returns the old contents
        mem_cycle(1'b1, 8'h10, 12'h0F0, 1'b0, 8'h00);
        mem_cycle(1'b1, 8'h10, 12'h123, 1'b1, 8'h10);
        check("rd_collision_old", 32'(RdData), 32'h0F0);
        mem_cycle(1'b0, 8'h00, 12'h000, 1'b1, 8'h10);
        check("rd_after_collision", 32'(RdData), 32'h123);

        // RdEn low holds RdData
        for (int i = 0; i < 3; i++) mem_cycle(1'b0, 8'($urandom), 12'($urandom), 1'b0, 8'($urandom));

        // Reset clears outputs but keeps contents
        Reset = 1'b0;
        #1;
        check("rst_rd_mid", 32'(RdData), 32'd0);
        check("rst_wr_mid", 32'(WrDataOut), 32'd0);
        #1;
        Reset  = 1'b1;
        exp_rd = '0;
        exp_wr = '0;
        mem_cycle(1'b0, 8'h00, 12'h000, 1'b1, 8'h10);
        check("rd_kept_thru_reset", 32'(RdData), 32'h123);

        // Fill, then random two-port traffic against the array model
        for (int a = 0; a < 256; a++) begin
            WrEn   = 1'b1;
            WrAddr = 8'(a);
            WrData = 12'($urandom);
            mdl[a] = WrData;
            exp_wr = WrData;
            RdEn   = 1'b0;
            tick();
        end
        check("fill_wr", 32'(WrDataOut), 32'(exp_wr));
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ra;
            ra = 8'($urandom);
            mem_cycle(1'($urandom), ($urandom_range(0, 3) == 0) ? ra : 8'($urandom), 12'($urandom),
                      1'($urandom), ra);
        end
        WrEn = 1'b0;
        RdEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
